// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_muldiv_pkg : HI/LO unit op codes, divide FSM states, constants  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } divState_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_core : iterative 32-bit unsigned restoring divider, 1 bit/step   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // Quotient register doubles as the dividend shifter feeding the remainder.
  assign w_shift = {r_rem, r_quot[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (load) begin
      r_rem     <= '0;
      r_quot    <= dividend;
      r_divisor <= divisor;
    end else if (step) begin
      if (!w_diff[32]) begin
        r_rem  <= w_diff[31:0];
        r_quot <= {r_quot[30:0], 1'b1};
      end else begin
        r_rem  <= w_shift[31:0];
        r_quot <= {r_quot[30:0], 1'b0};
      end
    end
  end

  assign quot = r_quot;
  assign rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_muldiv : HI/LO registers, 1-cycle multiply, 33-cycle divide     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_hi,
  output logic [31:0] hi_lo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  divState_e          r_state;
  divState_e          w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_quotNeg;
  logic               r_remNeg;
  logic               r_divZero;
  logic               w_accept;
  logic               w_load;
  logic               w_step;
  logic               w_fixWrite;
  logic               w_isSigned;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [31:0]        w_aMag;
  logic [31:0]        w_bMag;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;
  logic [31:0]        w_quotFix;
  logic [31:0]        w_remFix;
  logic signed [63:0] w_prodS;
  logic [63:0]        w_prodU;
  op_e                w_opCode;

  assign w_opCode = op_e'(op);
  assign w_accept = op_valid && (r_state == ST_IDLE);

  assign w_prodS = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign w_prodU = {32'd0, src_a} * {32'd0, src_b};

  assign w_isSigned = (w_opCode == OP_DIV);
  assign w_aNeg     = w_isSigned && src_a[31];
  assign w_bNeg     = w_isSigned && src_b[31];
  assign w_aMag     = w_aNeg ? (32'd0 - src_a) : src_a;
  assign w_bMag     = w_bNeg ? (32'd0 - src_b) : src_b;

  div_core u_divCore (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .step     (w_step),
    .dividend (w_aMag),
    .divisor  (w_bMag),
    .quot     (w_quot),
    .rem      (w_rem)
  );

  // Divide by zero yields an all-ones quotient and the raw dividend as remainder.
  assign w_quotFix = r_divZero ? 32'hFFFF_FFFF : (r_quotNeg ? (32'd0 - w_quot) : w_quot);
  assign w_remFix  = r_remNeg ? (32'd0 - w_rem) : w_rem;

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fixWrite  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && ((w_opCode == OP_DIV) || (w_opCode == OP_DIVU))) begin
          w_stateNext = ST_DIV;
          w_cntNext   = '0;
          w_load      = 1'b1;
        end
      end
      ST_DIV: begin
        w_step    = 1'b1;
        w_cntNext = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DIV_ITERS - 1)) w_stateNext = ST_FIX;
      end
      ST_FIX: begin
        w_fixWrite  = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_quotNeg <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_load) begin
        r_quotNeg <= w_aNeg ^ w_bNeg;
        r_remNeg  <= w_aNeg;
        r_divZero <= (src_b == 32'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fixWrite) begin
      r_hi <= w_remFix;
      r_lo <= w_quotFix;
    end else if (w_accept) begin
      case (w_opCode)
        OP_MULT:  {r_hi, r_lo} <= w_prodS;
        OP_MULTU: {r_hi, r_lo} <= w_prodU;
        OP_MTHI:  r_hi <= src_a;
        OP_MTLO:  r_lo <= src_a;
        default:  ;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != ST_IDLE);
  assign hi_lo = rd_hi ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_muldiv : directed self-checking bench for hilo_muldiv        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic [31:0] hi_lo;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nCompared;
  int nMismatched;

  hilo_muldiv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .rd_hi    (rd_hi),
    .hi_lo    (hi_lo),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accepting edge; called at a falling edge.
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Counts sampled busy cycles and notes any hi/lo movement while busy.
  task automatic waitDiv(input logic [31:0] oldHi, input logic [31:0] oldLo,
                         output int cyc, output logic moved);
    cyc   = 0;
    moved = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== oldHi || lo !== oldLo) moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  int   cyc;
  logic moved;
  logic busySeen;

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    rd_hi    = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // MULT -3 * 5 accepted at the first edge after reset release
    doOp(3'd0, 32'hFFFF_FFFD, 32'd5);
    busySeen = busy;
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(negedge clk);
    busySeen = busySeen | busy;
    check("mult_busy", {31'd0, busySeen}, 32'd0);

    // MULTU max * max, then HI/LO read selects
    doOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    rd_hi = 1'b1;
    #1;
    check("mfhi", hi_lo, 32'hFFFF_FFFE);
    rd_hi = 1'b0;
    #1;
    check("mflo", hi_lo, 32'h0000_0001);
    @(negedge clk);

    // DIV -7 / 2
    doOp(3'd2, 32'hFFFF_FFF9, 32'd2);
    waitDiv(32'hFFFF_FFFE, 32'h0000_0001, cyc, moved);
    check("div_cycles", cyc, 32'd33);
    check("div_hold", {31'd0, moved}, 32'd0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 0
    doOp(3'd3, 32'd100, 32'd0);
    waitDiv(32'hFFFF_FFFF, 32'hFFFF_FFFD, cyc, moved);
    check("divu0_cycles", cyc, 32'd33);
    check("divu0_hi", hi, 32'd100);
    check("divu0_lo", lo, 32'hFFFF_FFFF);

    // DIV -5 / 0 keeps the signed dividend as remainder
    doOp(3'd2, 32'hFFFF_FFFB, 32'd0);
    waitDiv(32'd100, 32'hFFFF_FFFF, cyc, moved);
    check("div0_hi", hi, 32'hFFFF_FFFB);
    check("div0_lo", lo, 32'hFFFF_FFFF);

    // DIV overflow case
    doOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDiv(32'hFFFF_FFFB, 32'hFFFF_FFFF, cyc, moved);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // DIVU 100 / 7 with MTHI held while busy
    doOp(3'd3, 32'd100, 32'd7);
    op_valid = 1'b1;
    op       = 3'd4;
    src_a    = 32'h0000_1234;
    waitDiv(32'd0, 32'h8000_0000, cyc, moved);
    check("mthi_busy_cycles", cyc, 32'd33);
    check("mthi_ignored", {31'd0, moved}, 32'd0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    @(negedge clk);
    op_valid = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'd14);

    // No-op codes change nothing
    doOp(3'd6, 32'hDEAD_BEEF, 32'h1111_1111);
    doOp(3'd7, 32'hCAFE_F00D, 32'h2222_2222);
    check("nop_hi", hi, 32'h0000_1234);
    check("nop_lo", lo, 32'd14);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // MTLO: read in the write cycle returns the old value
    op_valid = 1'b1;
    op       = 3'd5;
    src_a    = 32'h0000_ABCD;
    #1;
    check("mtlo_old_read", hi_lo, 32'd14);
    @(negedge clk);
    op_valid = 1'b0;
    check("mtlo_lo", lo, 32'h0000_ABCD);
    check("mtlo_hi", hi, 32'h0000_1234);

    // Reset in the middle of a divide
    doOp(3'd4, 32'd5, 32'd0);
    doOp(3'd5, 32'd5, 32'd0);
    doOp(3'd2, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitDiv(32'd0, 32'd0, cyc, moved);
    repeat (40) begin
      @(negedge clk);
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) moved = 1'b1;
    end
    check("rst_no_write", {31'd0, moved}, 32'd0);
    check("rst_final_hi", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
